// File: rtl/ball_pkg.sv
// Shared types and screen constants for the ball physics stage.
package ball_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int POS_W    = 10;
   localparam int VEL_W    = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_WRITE,
      S_NEXT
   } state_e;

   typedef struct packed {
      logic [POS_W-1:0]        x;
      logic [POS_W-1:0]        y;
      logic signed [VEL_W-1:0] vx;
      logic signed [VEL_W-1:0] vy;
      logic                    alive;
   } ball_t;

   typedef logic signed [11:0] s12_t;

   function automatic logic signed [VEL_W-1:0] vabs(input logic signed [VEL_W-1:0] v);
      return (v < 0) ? -v : v;
   endfunction

endpackage

// File: rtl/ball_collide.sv
// Combinational one-frame step for a single ball: move, wall/ceiling/paddle bounce, loss.
// Optional paddle spin on vx is enabled by defining BALL_SPIN_EN.
module ball_collide
   import ball_pkg::*;
#(
   parameter int PADDLE_Y = 440,
   parameter int PADDLE_W = 64
) (
   input  ball_t            ball_i,
   input  logic [POS_W-1:0] paddle_x_i,
   input  logic [5:0]       radius_i,
   output ball_t            ball_o,
   output logic             lost_o
);

   localparam s12_t PY   = s12_t'(PADDLE_Y);
   localparam s12_t PW   = s12_t'(PADDLE_W);
   localparam s12_t XMAX = s12_t'(SCREEN_W - 1);
   localparam s12_t YMAX = s12_t'(SCREEN_H - 1);

   s12_t r, px, x0, y0, nx_raw, ny_raw, nx, ny;
   logic signed [VEL_W-1:0] vx, vy;
   logic hit, dead;
`ifdef BALL_SPIN_EN
   logic signed [VEL_W:0] vs;
`endif

   assign r      = $signed({6'd0, radius_i});
   assign px     = $signed({2'b00, paddle_x_i});
   assign x0     = $signed({2'b00, ball_i.x});
   assign y0     = $signed({2'b00, ball_i.y});
   assign nx_raw = x0 + {{(12-VEL_W){ball_i.vx[VEL_W-1]}}, ball_i.vx};
   assign ny_raw = y0 + {{(12-VEL_W){ball_i.vy[VEL_W-1]}}, ball_i.vy};

   always_comb begin
      nx = nx_raw;
      vx = ball_i.vx;
      if (nx_raw < r) begin
         nx = r;
         vx = vabs(ball_i.vx);
      end else if (nx_raw > XMAX - r) begin
         nx = XMAX - r;
         vx = -vabs(ball_i.vx);
      end

      ny = ny_raw;
      vy = ball_i.vy;
      if (ny_raw < r) begin
         ny = r;
         vy = vabs(ball_i.vy);
      end

      // Only a ball crossing the paddle top this frame can bounce off it.
      hit = (ball_i.vy > 0) && (ny + r >= PY) && (y0 + r < PY) &&
            (nx >= px) && (nx < px + PW);
`ifdef BALL_SPIN_EN
      vs = {vx[VEL_W-1], vx};
`endif
      if (hit) begin
         ny = PY - r;
         vy = -ball_i.vy;
`ifdef BALL_SPIN_EN
         if (nx < px + (PW >>> 2))
            vs = {vx[VEL_W-1], vx} - 5'sd1;
         else if (nx >= px + PW - (PW >>> 2))
            vs = {vx[VEL_W-1], vx} + 5'sd1;
         if (vs > 5'sd7)  vs = 5'sd7;
         if (vs < -5'sd7) vs = -5'sd7;
         if (vs != 5'sd0) vx = vs[VEL_W-1:0];
`endif
      end

      dead = !hit && (ny - r > YMAX);

      ball_o = ball_i;
      lost_o = 1'b0;
      if (ball_i.alive) begin
         if (dead) begin
            ball_o.alive = 1'b0;
            lost_o       = 1'b1;
         end else begin
            ball_o.x  = nx[POS_W-1:0];
            ball_o.y  = ny[POS_W-1:0];
            ball_o.vx = vx;
            ball_o.vy = vy;
         end
      end
   end

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball physics: sequential CALC/WRITE/NEXT sweep over CNT slots plus paddle launches.
// Paddle spin is compiled in when BALL_SPIN_EN is defined (see ball_collide).
module ball_motion
   import ball_pkg::*;
#(
   parameter int CNT      = 3,
   parameter int PADDLE_Y = 440,
   parameter int PADDLE_W = 64,
   parameter int INIT_VX  = 2,
   parameter int INIT_VY  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_tick,
   input  logic                 launch,
   input  logic [POS_W-1:0]     paddle_x,
   input  logic [5:0]           radius,
   output logic [CNT*POS_W-1:0] xs,
   output logic [CNT*POS_W-1:0] ys,
   output logic [CNT-1:0]       active,
   output logic                 busy,
   output logic                 update_done,
   output logic                 lost,
   output logic                 launch_ack
);

   localparam int IDX_W = (CNT > 1) ? $clog2(CNT) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(CNT - 1);

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   ball_t            balls_q [CNT];
   ball_t            calc_q;
   logic             calc_lost_q;
   logic             busy_q, done_q, lost_q, ack_q, pending_q;

   ball_t            cur_d, nxt_d, launch_d;
   logic             nxt_lost_d;
   logic             free_found_d;
   logic [IDX_W-1:0] free_idx_d;

   assign cur_d = balls_q[idx_q];

   ball_collide #(
      .PADDLE_Y (PADDLE_Y),
      .PADDLE_W (PADDLE_W)
   ) u_collide (
      .ball_i     (cur_d),
      .paddle_x_i (paddle_x),
      .radius_i   (radius),
      .ball_o     (nxt_d),
      .lost_o     (nxt_lost_d)
   );

   // Lowest-index dead slot receives the next launched ball.
   always_comb begin
      free_found_d = 1'b0;
      free_idx_d   = '0;
      for (int i = CNT - 1; i >= 0; i--) begin
         if (!balls_q[i].alive) begin
            free_found_d = 1'b1;
            free_idx_d   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      launch_d.x     = paddle_x + POS_W'(PADDLE_W / 2);
      launch_d.y     = POS_W'(PADDLE_Y) - {4'd0, radius} - 10'd1;
      launch_d.vx    = VEL_W'(INIT_VX);
      launch_d.vy    = VEL_W'(-INIT_VY);
      launch_d.alive = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         calc_q      <= '0;
         calc_lost_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         lost_q      <= 1'b0;
         ack_q       <= 1'b0;
         pending_q   <= 1'b0;
         for (int i = 0; i < CNT; i++) balls_q[i] <= '0;
      end else begin
         done_q <= 1'b0;
         lost_q <= 1'b0;
         ack_q  <= 1'b0;
         if (launch) pending_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (frame_tick) begin
                  state_q <= S_CALC;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
               end else if (pending_q) begin
                  pending_q <= launch;
                  if (free_found_d) begin
                     balls_q[free_idx_d] <= launch_d;
                     ack_q               <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               calc_q      <= nxt_d;
               calc_lost_q <= nxt_lost_d;
               state_q     <= S_WRITE;
            end
            S_WRITE: begin
               balls_q[idx_q] <= calc_q;
               lost_q         <= calc_lost_q;
               state_q        <= S_NEXT;
            end
            S_NEXT: begin
               if (idx_q == LAST) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  idx_q   <= idx_q + 1'b1;
                  state_q <= S_CALC;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   for (genvar gi = 0; gi < CNT; gi++) begin : g_out
      assign xs[gi*POS_W +: POS_W] = balls_q[gi].x;
      assign ys[gi*POS_W +: POS_W] = balls_q[gi].y;
      assign active[gi]            = balls_q[gi].alive;
   end

   assign busy        = busy_q;
   assign update_done = done_q;
   assign lost        = lost_q;
   assign launch_ack  = ack_q;

endmodule
